// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory controller.
//   - typeData encodings (access size)
//   - read/write encodings of the RW strobe
//   - FSM state type
//   - type_bytes(): number of bytes moved by an access of a given type
package mem_pkg;

  localparam logic [1:0] TD_BYTE = 2'b00;
  localparam logic [1:0] TD_HALF = 2'b01;
  localparam logic [1:0] TD_WORD = 2'b10;
  localparam logic [1:0] TD_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Reserved type reports one byte so range arithmetic stays well defined;
  // the access is rejected by the type check anyway.
  function automatic logic [2:0] type_bytes(input logic [1:0] td);
    case (td)
      TD_HALF: type_bytes = 3'd2;
      TD_WORD: type_bytes = 3'd4;
      default: type_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for a latched memory access.
// Ports:
//   addr   in  ADDR_W  byte address of the most significant byte
//   td     in  2       access type (byte / half / word / reserved)
//   err    out 1       access must be rejected
//   nbytes out 3       bytes moved by this access type (1, 2 or 4)
module mem_access_check
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        td,
  output logic              err,
  output logic [2:0]        nbytes
);

  // Two spare bits so address + size - 1 cannot wrap at the top of the map.
  localparam int LAST_W = ADDR_W + 2;

  logic [LAST_W-1:0] last_byte;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a missed branch infers a latch.
  always_comb begin
    nbytes    = type_bytes(td);
    last_byte = {2'b00, addr} + LAST_W'(nbytes) - LAST_W'(1);
    err       = 1'b0;
    if (td == TD_RSVD)                          err = 1'b1;
    if (td == TD_HALF && addr[0])               err = 1'b1;
    if (td == TD_WORD && addr[1:0] != 2'b00)    err = 1'b1;
    if (last_byte >= LAST_W'(DEPTH))            err = 1'b1;
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Byte-addressed big-endian memory with a MOV/MOC four-phase handshake and
// WAIT_CYCLES programmable wait states.
// Ports:
//   CLK      in  1       rising-edge clock
//   CLR      in  1       asynchronous active-high reset
//   MOV      in  1       operation valid, held until MOC is seen
//   RW       in  1       1 = read, 0 = write
//   typeData in  2       00 byte, 01 half, 10 word, 11 reserved
//   Address  in  ADDR_W  address of the most significant byte
//   DataIn   in  32      right-justified write data
//   DataOut  out 32      right-justified, zero-extended read data
//   MOC      out 1       operation complete
//   ERR      out 1       access rejected, valid while MOC = 1
module mem_wait_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        typeData,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR
);

  // Counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [7:0] mem [0:DEPTH-1];

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              rw_q;
  logic [1:0]        td_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic              acc_err;
  logic [2:0]        acc_nbytes;
  logic              fire;
  logic              do_read, do_write;
  logic [31:0]       din_left;
  logic [31:0]       rd_data;

  mem_access_check #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_check (
    .addr   (addr_q),
    .td     (td_q),
    .err    (acc_err),
    .nbytes (acc_nbytes)
  );

  // The access edge only counts if the master is still requesting.
  assign fire     = (state == S_ACCESS) && MOV;
  assign do_read  = fire && !acc_err && (rw_q == RW_READ);
  assign do_write = fire && !acc_err && (rw_q == RW_WRITE);
  assign MOC      = (state == S_DONE);

  // Left-justify write data so byte i of the access is always [31-8i -: 8].
  assign din_left = din_q << {3'd4 - acc_nbytes, 3'b000};

  // Big-endian gather: lowest address ends up most significant.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < acc_nbytes) rd_data = {rd_data[23:0], mem[addr_q + ADDR_W'(i)]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (MOV) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT: begin
        if (!MOV)            state_nxt = S_IDLE;
        else if (cnt == '0)  state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = MOV ? S_DONE : S_IDLE;
      S_DONE:   if (!MOV) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt     <= '0;
      rw_q    <= 1'b0;
      td_q    <= 2'b00;
      addr_q  <= '0;
      din_q   <= '0;
      DataOut <= '0;
      ERR     <= 1'b0;
    end else begin
      if (state == S_IDLE && MOV) begin
        rw_q   <= RW;
        td_q   <= typeData;
        addr_q <= Address;
        din_q  <= DataIn;
        cnt    <= CNT_W'(WAIT_CYCLES - 1);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (fire)                     ERR <= acc_err;
      else if (state == S_DONE && !MOV) ERR <= 1'b0;
      if (do_read) DataOut <= rd_data;
    end
  end

  // NOTE: the array has no reset; it keeps contents across CLR and can be
  // preloaded hierarchically, and a reset here would block RAM inference.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < acc_nbytes) mem[addr_q + ADDR_W'(i)] <= din_left[31-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: one instance with two wait states and a
// full 256-byte map, one with zero wait states and a 200-byte map.
module tb_mem_wait_ctrl;
  import mem_pkg::*;

  logic        CLK;
  logic        CLR;
  logic        mov, mov0, RW;
  logic [1:0]  typeData;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] dout, dout0;
  logic        moc, moc0, err, err0;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_wait_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .CLR(CLR), .MOV(mov), .RW(RW), .typeData(typeData),
    .Address(Address), .DataIn(DataIn), .DataOut(dout), .MOC(moc), .ERR(err)
  );

  mem_wait_ctrl #(.ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .CLR(CLR), .MOV(mov0), .RW(RW), .typeData(typeData),
    .Address(Address), .DataIn(DataIn), .DataOut(dout0), .MOC(moc0), .ERR(err0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input bit sel, input logic rw, input logic [1:0] td,
                          input logic [7:0] a, input logic [31:0] d);
    RW = rw; typeData = td; Address = a; DataIn = d;
    if (sel) mov0 = 1'b1; else mov = 1'b1;
  endtask

  // n = edges from the sampling edge e0 until MOC is seen; 20 means never.
  // Inputs are scrambled after e0: only the latched copies may matter.
  task automatic wait_moc(input bit sel, output int n);
    @(posedge CLK); #1;
    Address = Address ^ 8'h55; DataIn = ~DataIn; RW = ~RW;
    n = 0;
    while (((sel ? moc0 : moc) !== 1'b1) && n < 20) begin
      @(posedge CLK); #1; n++;
    end
  endtask

  task automatic end_op(input bit sel);
    if (sel) mov0 = 1'b0; else mov = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    CLR = 1'b1; mov = 1'b0; mov0 = 1'b0; RW = 1'b1; typeData = TD_BYTE;
    Address = '0; DataIn = '0;
    #3;
    n_cmp++; if (moc !== 1'b0) begin n_fail++; $display("FAIL reset_moc: got %b want 0", moc); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_cmp++; if (moc0 !== 1'b0 || dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_dut0: got moc=%b dout=%h want 0/0", moc0, dout0); end
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_word_read;
    int n;
    dut.mem[0] = 8'hE3; dut.mem[1] = 8'hA0; dut.mem[2] = 8'h00; dut.mem[3] = 8'h05;
    start_op(0, RW_READ, TD_WORD, 8'd0, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL word_read_latency: got %0d want 3", n); end
    n_cmp++; if (dout !== 32'hE3A00005) begin n_fail++; $display("FAIL word_read_data: got %h want e3a00005", dout); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL word_read_err: got %b want 0", err); end
    end_op(0);
    n_cmp++; if (moc !== 1'b0) begin n_fail++; $display("FAIL word_read_moc_drop: got %b want 0", moc); end
  endtask

  task automatic test_half_write;
    int n;
    dut.mem[4] = 8'h11; dut.mem[5] = 8'h22;
    start_op(0, RW_WRITE, TD_HALF, 8'd6, 32'h0000BEEF);
    wait_moc(0, n);
    n_cmp++; if (n !== 3 || err !== 1'b0) begin n_fail++; $display("FAIL half_write: got lat=%0d err=%b want 3/0", n, err); end
    n_cmp++; if (dout !== 32'hE3A00005) begin n_fail++; $display("FAIL half_write_dout: got %h want e3a00005", dout); end
    end_op(0);
    start_op(0, RW_READ, TD_BYTE, 8'd6, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (dout !== 32'h000000BE) begin n_fail++; $display("FAIL byte_read_6: got %h want 000000be", dout); end
    end_op(0);
    start_op(0, RW_READ, TD_BYTE, 8'd7, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (dout !== 32'h000000EF) begin n_fail++; $display("FAIL byte_read_7: got %h want 000000ef", dout); end
    end_op(0);
    n_cmp++; if (dut.mem[4] !== 8'h11 || dut.mem[5] !== 8'h22) begin n_fail++; $display("FAIL half_write_neighbours: got %h %h want 11 22", dut.mem[4], dut.mem[5]); end
  endtask

  task automatic test_errors;
    int n;
    dut.mem[252] = 8'h01; dut.mem[253] = 8'h02; dut.mem[254] = 8'h5A; dut.mem[255] = 8'hA5;
    start_op(0, RW_READ, TD_WORD, 8'd2, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (n !== 3 || err !== 1'b1) begin n_fail++; $display("FAIL misaligned_word: got lat=%0d err=%b want 3/1", n, err); end
    n_cmp++; if (dout !== 32'h000000EF) begin n_fail++; $display("FAIL misaligned_dout: got %h want 000000ef", dout); end
    end_op(0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    start_op(0, RW_READ, TD_RSVD, 8'd0, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (err !== 1'b1 || dout !== 32'h000000EF) begin n_fail++; $display("FAIL reserved_type: got err=%b dout=%h want 1/000000ef", err, dout); end
    end_op(0);
    start_op(0, RW_WRITE, TD_WORD, 8'd254, 32'hAABBCCDD);
    wait_moc(0, n);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL word_write_254: got err=%b want 1", err); end
    end_op(0);
    n_cmp++; if (dut.mem[254] !== 8'h5A || dut.mem[255] !== 8'hA5) begin n_fail++; $display("FAIL word_write_254_mem: got %h %h want 5a a5", dut.mem[254], dut.mem[255]); end
    start_op(0, RW_READ, TD_HALF, 8'd255, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL half_read_255: got err=%b want 1", err); end
    end_op(0);
    start_op(0, RW_READ, TD_WORD, 8'd252, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (err !== 1'b0 || dout !== 32'h01025AA5) begin n_fail++; $display("FAIL word_read_252: got err=%b dout=%h want 0/01025aa5", err, dout); end
    end_op(0);
  endtask

  task automatic test_back_to_back;
    int n;
    bit hold_ok;
    start_op(0, RW_READ, TD_WORD, 8'd0, 32'h0);
    wait_moc(0, n);
    hold_ok = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      if (moc !== 1'b1 || dout !== 32'hE3A00005) hold_ok = 1'b0;
    end
    n_cmp++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL hold_moc: got moc=%b dout=%h want 1/e3a00005", moc, dout); end
    end_op(0);
    n_cmp++; if (moc !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL hold_release: got moc=%b err=%b want 0/0", moc, err); end
    start_op(0, RW_READ, TD_BYTE, 8'd1, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (n !== 3 || dout !== 32'h000000A0) begin n_fail++; $display("FAIL back_to_back: got lat=%0d dout=%h want 3/000000a0", n, dout); end
    end_op(0);
  endtask

  task automatic test_abort;
    bit saw_moc;
    for (int i = 8; i < 12; i++) dut.mem[i] = 8'h00;
    // Drop MOV during WAIT.
    start_op(0, RW_WRITE, TD_WORD, 8'd8, 32'h12345678);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mov = 1'b0;
    saw_moc = 1'b0;
    repeat (6) begin @(posedge CLK); #1; if (moc !== 1'b0) saw_moc = 1'b1; end
    n_cmp++; if (saw_moc !== 1'b0) begin n_fail++; $display("FAIL abort_wait_moc: got moc pulse want none"); end
    n_cmp++; if (dut.state !== S_IDLE) begin n_fail++; $display("FAIL abort_wait_state: got %0d want %0d", dut.state, S_IDLE); end
    n_cmp++; if ({dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]} !== 32'h0) begin n_fail++; $display("FAIL abort_wait_mem: got %h want 0", {dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]}); end
    // Drop MOV so the ACCESS edge samples it low.
    start_op(0, RW_WRITE, TD_WORD, 8'd8, 32'h12345678);
    repeat (3) begin @(posedge CLK); #1; end
    n_cmp++; if (dut.state !== S_ACCESS) begin n_fail++; $display("FAIL abort_access_state: got %0d want %0d", dut.state, S_ACCESS); end
    mov = 1'b0;
    saw_moc = 1'b0;
    repeat (4) begin @(posedge CLK); #1; if (moc !== 1'b0) saw_moc = 1'b1; end
    n_cmp++; if (saw_moc !== 1'b0 || {dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]} !== 32'h0) begin n_fail++; $display("FAIL abort_access: got moc_seen=%b mem=%h want 0/0", saw_moc, {dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]}); end
    n_cmp++; if (dout !== 32'h000000A0) begin n_fail++; $display("FAIL abort_dout: got %h want 000000a0", dout); end
  endtask

  task automatic test_clr;
    int n;
    for (int i = 12; i < 16; i++) dut.mem[i] = 8'h77;
    start_op(0, RW_WRITE, TD_WORD, 8'd12, 32'hDEADBEEF);
    @(posedge CLK); #1;
    #2 CLR = 1'b1;
    #1;
    n_cmp++; if (moc !== 1'b0 || dout !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL clr_async: got moc=%b dout=%h err=%b want 0/0/0", moc, dout, err); end
    n_cmp++; if (dut.state !== S_IDLE) begin n_fail++; $display("FAIL clr_state: got %0d want %0d", dut.state, S_IDLE); end
    CLR = 1'b0; mov = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++; if ({dut.mem[12], dut.mem[13], dut.mem[14], dut.mem[15]} !== 32'h77777777) begin n_fail++; $display("FAIL clr_mem: got %h want 77777777", {dut.mem[12], dut.mem[13], dut.mem[14], dut.mem[15]}); end
    start_op(0, RW_READ, TD_WORD, 8'd0, 32'h0);
    wait_moc(0, n);
    n_cmp++; if (n !== 3 || dout !== 32'hE3A00005) begin n_fail++; $display("FAIL clr_recover: got lat=%0d dout=%h want 3/e3a00005", n, dout); end
    end_op(0);
  endtask

  task automatic test_wait0;
    int n;
    dut0.mem[0] = 8'h11; dut0.mem[1] = 8'h22; dut0.mem[2] = 8'h33; dut0.mem[3] = 8'h44;
    dut0.mem[198] = 8'h9A; dut0.mem[199] = 8'hBC;
    start_op(1, RW_READ, TD_WORD, 8'd0, 32'h0);
    wait_moc(1, n);
    n_cmp++; if (n !== 1 || dout0 !== 32'h11223344) begin n_fail++; $display("FAIL w0_word_read: got lat=%0d dout=%h want 1/11223344", n, dout0); end
    end_op(1);
    n_cmp++; if (moc0 !== 1'b0) begin n_fail++; $display("FAIL w0_moc_drop: got %b want 0", moc0); end
    start_op(1, RW_WRITE, TD_HALF, 8'd2, 32'h0000CAFE);
    wait_moc(1, n);
    n_cmp++; if (n !== 1 || err0 !== 1'b0) begin n_fail++; $display("FAIL w0_half_write: got lat=%0d err=%b want 1/0", n, err0); end
    end_op(1);
    start_op(1, RW_READ, TD_WORD, 8'd0, 32'h0);
    wait_moc(1, n);
    n_cmp++; if (dout0 !== 32'h1122CAFE) begin n_fail++; $display("FAIL w0_readback: got %h want 1122cafe", dout0); end
    end_op(1);
    start_op(1, RW_READ, TD_HALF, 8'd198, 32'h0);
    wait_moc(1, n);
    n_cmp++; if (err0 !== 1'b0 || dout0 !== 32'h00009ABC) begin n_fail++; $display("FAIL w0_half_198: got err=%b dout=%h want 0/00009abc", err0, dout0); end
    end_op(1);
    start_op(1, RW_READ, TD_WORD, 8'd200, 32'h0);
    wait_moc(1, n);
    n_cmp++; if (n !== 1 || err0 !== 1'b1 || dout0 !== 32'h00009ABC) begin n_fail++; $display("FAIL w0_range_200: got lat=%0d err=%b dout=%h want 1/1/00009abc", n, err0, dout0); end
    end_op(1);
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_half_write;
    test_errors;
    test_back_to_back;
    test_abort;
    test_clr;
    test_wait0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
